convert_sched: RTL and testbench
================================

Name: convert_sched

Overview:
Sequencer for the down-conversion DDS retune loop.
- Triggers an FFT capture and waits for the detected peak address.
- Maps the peak address to a 32-bit DDS frequency control word.
- Glides the DDS word toward that target in bounded steps, waits for the loop to settle, then recaptures.
- Arbitrates against manual frequency requests arriving from the UART path; UART requests always win.

Parameters:
FREQ_COEFF, 22, left shift from bin address to control word (K = addr·2^22 at 50 MHz).
ADDR_OFFSET, 3, bin offset subtracted when addr >= ADDR_OFFSET.
GLIDE_STEP, 21474836, maximum word change per update (0.25 MHz).
GLIDE_DIV, 4, cycles between glide updates (>=1).
SETTLE_CYCLES, 1024, wait after the glide completes before the next capture (>=1).
TIMEOUT_CYCLES, 65536, maximum wait for a peak in CAPTURE (>=2).

Ports:
sys_clk  in  1  clock.
sys_rstn  in  1  reset, asynchronous, active-low.
enable  in  1  run automatic loop; level.
fft_start  out  1  one-cycle pulse that starts an FFT capture/detect.
peak_valid  in  1  one-cycle pulse; peak_addr is valid.
peak_addr  in  16  detected peak bin address.
uart_freq_valid  in  1  one-cycle pulse; manual word request.
uart_freq_word  in  32  manual target control word.
uart_mode  in  1  1 = manual lock (no recapture), 0 = auto.
dds_word  out  32  current DDS frequency control word.
dds_word_valid  out  1  one-cycle pulse on every dds_word change.
busy  out  1  high in CAPTURE/CALC/GLIDE/SETTLE.
timeout_err  out  1  one-cycle pulse on capture timeout.
state  out  3  current state encoding, for debug.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal target, counters and flags 0.
- Reset is asynchronous and may assert in any state. On release, operation restarts from IDLE with dds_word=0. There is no resume.

States:
- IDLE. If enable=1, go to CAPTURE next cycle; otherwise stay.
- CAPTURE.
  - fft_start=1 in the first cycle only; the timeout counter clears on entry.
  - On peak_valid, latch peak_addr and go to CALC.
  - If the counter reaches TIMEOUT_CYCLES-1 with no peak, pulse timeout_err and go to IDLE.
- CALC (1 cycle).
  - target = ((addr>=ADDR_OFFSET) ? addr-ADDR_OFFSET : addr) << FREQ_COEFF, computed in 32 bits; upper bits are truncated.
  - Then go to GLIDE.
- GLIDE.
  - The divider counter is zeroed on entry; an update fires when it is 0, then it counts 1..GLIDE_DIV-1 and wraps.
  - First update happens on the first GLIDE cycle.
  - Each update (unsigned compare):
    - if |target-dds_word| <= GLIDE_STEP, then dds_word=target;
    - else dds_word moves by ±GLIDE_STEP toward target.
  - dds_word_valid pulses in the cycle after the dds_word register changes. No pulse if the value is unchanged.
  - When dds_word==target at an update slot: go to HOLD if the manual flag is set, otherwise SETTLE.
- SETTLE.
  - Count SETTLE_CYCLES cycles, then go to CAPTURE.
  - If enable=0, go to IDLE instead.
- HOLD. Manual lock; dds_word is frozen. If uart_mode=0, go to IDLE.

Arbitration / boundary rules:
- uart_freq_valid is accepted in every state, including mid-CAPTURE and mid-GLIDE. Effect:
  - target=uart_freq_word, manual flag set to uart_mode, and the next state is GLIDE.
  - A pending capture is abandoned and its late peak is dropped.
- uart_freq_valid and peak_valid in the same cycle: UART wins and the peak is discarded.
- peak_valid outside CAPTURE is ignored.
- enable falling during CAPTURE or SETTLE: go to IDLE next cycle. A glide in progress completes first.
- Manual flag clears on IDLE entry.
- Target equal to the current word: GLIDE lasts 1 cycle with no valid pulse.
- Glide arithmetic must not wrap: compute the difference before stepping.

Decomposition:
- Package convert_pkg holds:
  - state encoding: IDLE=0, CAPTURE=1, CALC=2, GLIDE=3, SETTLE=4, HOLD=5;
  - the FREQ_COEFF and ADDR_OFFSET defaults;
  - the addr-to-word mapping function.
- One sub-module, freq_glide: holds dds_word, the divider counter and the step/compare logic; outputs done and the valid pulse. The FSM stays in convert_sched.

Test Plan:
Use GLIDE_DIV=4, SETTLE_CYCLES=16, TIMEOUT_CYCLES=64.
1. enable=1, peak_addr=10 -> fft_start pulse, CALC target 0x01C00000; dds_word 0x0147AE14 then 0x01C00000, 4 cycles apart; 2 valid pulses; 16 cycles later a new fft_start.
2. peak_addr=2 -> target 0x00800000 in one step. peak_addr=3 from dds_word=0 -> target 0, no valid pulse, straight to SETTLE.
3. No peak_valid for 64 cycles -> timeout_err pulse, IDLE, then fft_start again next-but-one cycle; dds_word unchanged.
4. uart_freq_word=0x10000000, uart_mode=1 during CAPTURE, plus a later peak_valid -> peak ignored; glide reaches 0x10000000 after 13 updates (12×GLIDE_STEP, then final); HOLD with no fft_start. Drop uart_mode -> IDLE -> CAPTURE.
5. uart_freq_valid and peak_valid in the same cycle -> UART target used, peak discarded.
6. sys_rstn asserted mid-GLIDE -> dds_word=0, all outputs 0 immediately; after release, restart from IDLE.

Source files
------------

// File: rtl/convert_pkg.sv
// Shared definitions for the DDS retune sequencer: state encoding,
// default bin-to-word mapping constants and the mapping helper.
package convert_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CAPTURE = 3'd1,
      CALC    = 3'd2,
      GLIDE   = 3'd3,
      SETTLE  = 3'd4,
      HOLD    = 3'd5
   } SchedState;

   localparam int unsigned FREQ_COEFF_DEF  = 22;
   localparam int unsigned ADDR_OFFSET_DEF = 3;

   // Bin address to DDS control word: remove the bin offset when it would not
   // underflow, then scale by a power of two; anything above bit 31 is dropped.
   function automatic logic [31:0] addrToWord(input logic [15:0]   addr,
                                              input int unsigned   offset,
                                              input int unsigned   coeff);
      logic [31:0] a;
      a = {16'd0, addr};
      if (a >= offset) begin
         a = a - offset;
      end
      return a << coeff;
   endfunction

endpackage

// File: rtl/convert_sched_glide.sv
// DDS word glider: owns the live control word, the update-rate divider and
// the bounded step toward the requested target.
module freq_glide #(
   parameter int unsigned GLIDE_STEP = 21474836,
   parameter int unsigned GLIDE_DIV  = 4
) (
   input  logic        sys_clk,
   input  logic        sys_rstn,
   input  logic        i_active,
   input  logic        i_clear,
   input  logic [31:0] i_target,
   output logic [31:0] o_dds_word,
   output logic        o_dds_word_valid,
   output logic        o_done
);

   localparam int                DIV_W    = $clog2(GLIDE_DIV) + 1;
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(GLIDE_DIV - 1);
   localparam logic [31:0]       STEP     = 32'(GLIDE_STEP);

   logic [31:0]      r_word;
   logic [DIV_W-1:0] r_div;
   logic             r_valid;

   logic             w_slot;
   logic             w_up;
   logic [31:0]      w_diff;
   logic [31:0]      w_stepped;
   logic             w_fire;

   // Step calculation: take the distance first so the move can never wrap past the target.
   always_comb begin
      w_slot = i_active && (r_div == '0);
      w_up   = (i_target >= r_word);
      w_diff = w_up ? (i_target - r_word) : (r_word - i_target);
      if (w_diff <= STEP) begin
         w_stepped = i_target;
      end else if (w_up) begin
         w_stepped = r_word + STEP;
      end else begin
         w_stepped = r_word - STEP;
      end
      w_fire = w_slot && !i_clear && (r_word != i_target);
   end

   // Update divider: parked at zero outside a glide and restarted by a new request.
   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         r_div <= '0;
      end else if (i_clear || !i_active) begin
         r_div <= '0;
      end else if (r_div == DIV_LAST) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   // Control word register; the valid flag rises alongside each real change.
   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         r_word  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= w_fire;
         if (w_fire) begin
            r_word <= w_stepped;
         end
      end
   end

   assign o_dds_word       = r_word;
   assign o_dds_word_valid = r_valid;
   assign o_done           = w_slot && (r_word == i_target);

endmodule

// File: rtl/convert_sched.sv
// Retune sequencer: capture a spectrum peak, map it to a DDS word, glide
// there, settle and repeat; manual UART requests pre-empt everything.
module convert_sched
   import convert_pkg::*;
#(
   parameter int unsigned FREQ_COEFF     = FREQ_COEFF_DEF,
   parameter int unsigned ADDR_OFFSET    = ADDR_OFFSET_DEF,
   parameter int unsigned GLIDE_STEP     = 21474836,
   parameter int unsigned GLIDE_DIV      = 4,
   parameter int unsigned SETTLE_CYCLES  = 1024,
   parameter int unsigned TIMEOUT_CYCLES = 65536
) (
   input  logic        sys_clk,
   input  logic        sys_rstn,
   input  logic        enable,
   output logic        fft_start,
   input  logic        peak_valid,
   input  logic [15:0] peak_addr,
   input  logic        uart_freq_valid,
   input  logic [31:0] uart_freq_word,
   input  logic        uart_mode,
   output logic [31:0] dds_word,
   output logic        dds_word_valid,
   output logic        busy,
   output logic        timeout_err,
   output logic [2:0]  state
);

   localparam int unsigned      CNT_MAX      = (TIMEOUT_CYCLES > SETTLE_CYCLES) ?
                                               TIMEOUT_CYCLES : SETTLE_CYCLES;
   localparam int               CNT_W        = $clog2(CNT_MAX) + 1;
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);

   SchedState        r_state;
   SchedState        w_nextState;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_target;
   logic [15:0]      r_peakAddr;
   logic             r_manual;

   logic             w_glideActive;
   logic             w_glideDone;
   logic             w_timeoutHit;
   logic             w_settleHit;

   assign w_glideActive = (r_state == GLIDE);
   assign w_timeoutHit  = (r_cnt == TIMEOUT_LAST);
   assign w_settleHit   = (r_cnt == SETTLE_LAST);

   // State register.
   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state selection; a UART request overrides whatever the loop was doing.
   always_comb begin
      w_nextState = r_state;
      if (uart_freq_valid) begin
         w_nextState = GLIDE;
      end else begin
         case (r_state)
            IDLE:    if (enable) w_nextState = CAPTURE;
            CAPTURE: begin
               if (!enable)           w_nextState = IDLE;
               else if (peak_valid)   w_nextState = CALC;
               else if (w_timeoutHit) w_nextState = IDLE;
            end
            CALC:    w_nextState = GLIDE;
            GLIDE:   if (w_glideDone) w_nextState = r_manual ? HOLD : SETTLE;
            SETTLE: begin
               if (!enable)          w_nextState = IDLE;
               else if (w_settleHit) w_nextState = CAPTURE;
            end
            HOLD:    if (!uart_mode) w_nextState = IDLE;
            default: w_nextState = IDLE;
         endcase
      end
   end

   // State-derived outputs; the timeout only fires when nothing else claims the cycle.
   always_comb begin
      fft_start   = (r_state == CAPTURE) && (r_cnt == '0);
      busy        = (r_state == CAPTURE) || (r_state == CALC) ||
                    (r_state == GLIDE)   || (r_state == SETTLE);
      timeout_err = (r_state == CAPTURE) && enable && !uart_freq_valid &&
                    !peak_valid && w_timeoutHit;
   end

   // Shared in-state cycle counter for the capture timeout and the settle wait.
   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         r_cnt <= '0;
      end else if (w_nextState != r_state) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Target, latched peak and manual-lock flag.
   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         r_target   <= '0;
         r_peakAddr <= '0;
         r_manual   <= 1'b0;
      end else begin
         if ((r_state == CAPTURE) && peak_valid) begin
            r_peakAddr <= peak_addr;
         end
         if (uart_freq_valid) begin
            r_target <= uart_freq_word;
            r_manual <= uart_mode;
         end else begin
            if (r_state == CALC) begin
               r_target <= addrToWord(r_peakAddr, ADDR_OFFSET, FREQ_COEFF);
            end
            if (w_nextState == IDLE) begin
               r_manual <= 1'b0;
            end
         end
      end
   end

   freq_glide #(
      .GLIDE_STEP (GLIDE_STEP),
      .GLIDE_DIV  (GLIDE_DIV)
   ) uGlide (
      .sys_clk          (sys_clk),
      .sys_rstn         (sys_rstn),
      .i_active         (w_glideActive),
      .i_clear          (uart_freq_valid),
      .i_target         (r_target),
      .o_dds_word       (dds_word),
      .o_dds_word_valid (dds_word_valid),
      .o_done           (w_glideDone)
   );

   assign state = r_state;

endmodule

// File: tb/tb_convert_sched.sv
// Bench for the DDS retune sequencer: directed scenarios followed by random
// traffic, every cycle compared against a schedule-level reference model.
module tb_convert_sched;

   localparam int GLIDE_STEP     = 21474836;
   localparam int GLIDE_DIV      = 4;
   localparam int SETTLE_CYCLES  = 16;
   localparam int TIMEOUT_CYCLES = 64;
   localparam int FREQ_COEFF     = 22;
   localparam int ADDR_OFFSET    = 3;

   localparam int M_IDLE = 0, M_CAPTURE = 1, M_CALC = 2, M_GLIDE = 3, M_SETTLE = 4, M_HOLD = 5;

   logic        sys_clk;
   logic        sys_rstn;
   logic        enable;
   logic        fft_start;
   logic        peak_valid;
   logic [15:0] peak_addr;
   logic        uart_freq_valid;
   logic [31:0] uart_freq_word;
   logic        uart_mode;
   logic [31:0] dds_word;
   logic        dds_word_valid;
   logic        busy;
   logic        timeout_err;
   logic [2:0]  state;

   convert_sched #(
      .FREQ_COEFF     (FREQ_COEFF),
      .ADDR_OFFSET    (ADDR_OFFSET),
      .GLIDE_STEP     (GLIDE_STEP),
      .GLIDE_DIV      (GLIDE_DIV),
      .SETTLE_CYCLES  (SETTLE_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .sys_clk         (sys_clk),
      .sys_rstn        (sys_rstn),
      .enable          (enable),
      .fft_start       (fft_start),
      .peak_valid      (peak_valid),
      .peak_addr       (peak_addr),
      .uart_freq_valid (uart_freq_valid),
      .uart_freq_word  (uart_freq_word),
      .uart_mode       (uart_mode),
      .dds_word        (dds_word),
      .dds_word_valid  (dds_word_valid),
      .busy            (busy),
      .timeout_err     (timeout_err),
      .state           (state)
   );

   // Free-running clock, 10 time units per cycle.
   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int checks = 0;
   int passes = 0;

   // Reference model: phase, cycles spent in it, and the planned word sequence of a glide.
   int          mState;
   int          mAge;
   logic [31:0] mWord;
   logic        mValid;
   logic [31:0] mTarget;
   logic        mManual;
   logic [15:0] mAddr;
   logic [31:0] mSteps[$];

   logic [31:0] validQ[$];
   int          toCount;
   int          fftCount;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   function automatic logic [31:0] mapAddr(input logic [15:0] a);
      longint v;
      v = (a >= ADDR_OFFSET) ? longint'(a) - ADDR_OFFSET : longint'(a);
      v = v * (longint'(1) << FREQ_COEFF);
      return v[31:0];
   endfunction

   function automatic logic [31:0] qAt(input int i);
      if (i < validQ.size()) return validQ[i];
      return 32'hDEADBEEF;
   endfunction

   // Plan every intermediate word the glide will visit from the current word.
   task automatic buildSteps();
      longint w, t;
      logic [31:0] tmp;
      w = longint'(mWord);
      t = longint'(mTarget);
      mSteps.delete();
      for (int n = 0; n < 400 && w != t; n++) begin
         if (t > w) w = (t - w <= GLIDE_STEP) ? t : w + GLIDE_STEP;
         else       w = (w - t <= GLIDE_STEP) ? t : w - GLIDE_STEP;
         tmp = w[31:0];
         mSteps.push_back(tmp);
      end
   endtask

   task automatic modelReset();
      mState = M_IDLE; mAge = 0; mWord = '0; mValid = 1'b0;
      mTarget = '0; mManual = 1'b0; mAddr = '0; mSteps.delete();
   endtask

   task automatic stepModel(input bit en, input bit pv, input logic [15:0] pa,
                            input bit uv, input logic [31:0] uw, input bit um);
      int nxt;
      bit restart;
      int k;
      nxt = mState; restart = 0; mValid = 1'b0;
      if (uv) begin
         mTarget = uw; mManual = um; buildSteps(); nxt = M_GLIDE; restart = 1;
      end else begin
         case (mState)
            M_IDLE:    if (en) nxt = M_CAPTURE;
            M_CAPTURE: begin
               if (!en) nxt = M_IDLE;
               else if (pv) begin mAddr = pa; nxt = M_CALC; end
               else if (mAge == TIMEOUT_CYCLES - 1) nxt = M_IDLE;
            end
            M_CALC:    begin mTarget = mapAddr(mAddr); buildSteps(); nxt = M_GLIDE; end
            M_GLIDE:   if (mAge % GLIDE_DIV == 0) begin
               k = mAge / GLIDE_DIV;
               if (k < mSteps.size()) begin mWord = mSteps[k]; mValid = 1'b1; end
               else nxt = mManual ? M_HOLD : M_SETTLE;
            end
            M_SETTLE: begin
               if (!en) nxt = M_IDLE;
               else if (mAge == SETTLE_CYCLES - 1) nxt = M_CAPTURE;
            end
            M_HOLD:    if (!um) nxt = M_IDLE;
            default:   nxt = M_IDLE;
         endcase
      end
      if (nxt == M_IDLE) mManual = 1'b0;
      if (restart || nxt != mState) mAge = 0; else mAge++;
      mState = nxt;
   endtask

   task automatic checkAll();
      logic expFft, expBusy, expTo;
      expFft  = (mState == M_CAPTURE) && (mAge == 0);
      expBusy = (mState >= M_CAPTURE) && (mState <= M_SETTLE);
      expTo   = (mState == M_CAPTURE) && (mAge == TIMEOUT_CYCLES - 1) && enable &&
                !peak_valid && !uart_freq_valid;
      checkOutput("state", 32'(state), 32'(mState));
      checkOutput("dds_word", dds_word, mWord);
      checkOutput("dds_word_valid", 32'(dds_word_valid), 32'(mValid));
      checkOutput("fft_start", 32'(fft_start), 32'(expFft));
      checkOutput("busy", 32'(busy), 32'(expBusy));
      checkOutput("timeout_err", 32'(timeout_err), 32'(expTo));
   endtask

   // One clock cycle: drive inputs, compare outputs, advance DUT and model together.
   task automatic applyStimulus(input bit en, input bit pv, input logic [15:0] pa,
                                input bit uv, input logic [31:0] uw, input bit um);
      enable = en; peak_valid = pv; peak_addr = pa;
      uart_freq_valid = uv; uart_freq_word = uw; uart_mode = um;
      #1;
      checkAll();
      if (dds_word_valid === 1'b1) validQ.push_back(dds_word);
      if (timeout_err === 1'b1) toCount++;
      if (fft_start === 1'b1) fftCount++;
      @(posedge sys_clk);
      stepModel(en, pv, pa, uv, uw, um);
      #1;
   endtask

   task automatic idleCycles(input int n, input bit en, input bit um);
      for (int i = 0; i < n; i++) applyStimulus(en, 1'b0, 16'd0, 1'b0, 32'd0, um);
   endtask

   task automatic waitCapture();
      for (int i = 0; i < 300; i++) begin
         if (mState == M_CAPTURE) break;
         applyStimulus(1'b1, 1'b0, 16'd0, 1'b0, 32'd0, 1'b0);
      end
      checkOutput("reachCapture", 32'(state), 32'(M_CAPTURE));
   endtask

   // Asynchronous reset pulse between clock edges.
   task automatic doReset();
      enable = 1'b0; peak_valid = 1'b0; peak_addr = '0;
      uart_freq_valid = 1'b0; uart_freq_word = '0; uart_mode = 1'b0;
      sys_rstn = 1'b0;
      modelReset();
      #1;
      checkAll();
      #3 sys_rstn = 1'b1;
      @(posedge sys_clk);
      stepModel(1'b0, 1'b0, 16'd0, 1'b0, 32'd0, 1'b0);
      #1;
   endtask

   initial begin
      bit          curMode;
      bit          en, pv, uv;
      logic [15:0] pa;
      logic [31:0] uw;

      toCount = 0; fftCount = 0;
      enable = 1'b0; peak_valid = 1'b0; peak_addr = '0;
      uart_freq_valid = 1'b0; uart_freq_word = '0; uart_mode = 1'b0;
      sys_rstn = 1'b0;
      modelReset();
      #3;
      checkAll();
      #10 sys_rstn = 1'b1;
      @(posedge sys_clk);
      stepModel(1'b0, 1'b0, 16'd0, 1'b0, 32'd0, 1'b0);
      #1;
      idleCycles(3, 1'b0, 1'b0);

      $display("[TB] peak 10 capture and glide");
      waitCapture();
      idleCycles(3, 1'b1, 1'b0);
      validQ.delete(); fftCount = 0;
      applyStimulus(1'b1, 1'b1, 16'd10, 1'b0, 32'd0, 1'b0);
      idleCycles(40, 1'b1, 1'b0);
      checkOutput("t1ValidCount", 32'(validQ.size()), 32'd2);
      checkOutput("t1Step1", qAt(0), 32'h0147AE14);
      checkOutput("t1Step2", qAt(1), 32'h01C00000);
      checkOutput("t1Recapture", 32'(fftCount), 32'd1);

      $display("[TB] peak 2 and offset boundary");
      validQ.delete();
      applyStimulus(1'b1, 1'b1, 16'd2, 1'b0, 32'd0, 1'b0);
      idleCycles(30, 1'b1, 1'b0);
      checkOutput("t2ValidCount", 32'(validQ.size()), 32'd1);
      checkOutput("t2Word", qAt(0), 32'h00800000);
      applyStimulus(1'b1, 1'b1, 16'd3, 1'b0, 32'd0, 1'b0);
      idleCycles(30, 1'b1, 1'b0);
      checkOutput("t2Zero", dds_word, 32'd0);
      validQ.delete();
      applyStimulus(1'b1, 1'b1, 16'd3, 1'b0, 32'd0, 1'b0);
      idleCycles(2, 1'b1, 1'b0);
      checkOutput("t2SettleDirect", 32'(state), 32'(M_SETTLE));
      checkOutput("t2NoPulse", 32'(validQ.size()), 32'd0);

      $display("[TB] capture timeout");
      waitCapture();
      toCount = 0; fftCount = 0;
      idleCycles(66, 1'b1, 1'b0);
      checkOutput("t3TimeoutCount", 32'(toCount), 32'd1);
      checkOutput("t3FftCount", 32'(fftCount), 32'd2);
      checkOutput("t3WordKept", dds_word, 32'd0);
      idleCycles(3, 1'b0, 1'b0);

      $display("[TB] manual lock during capture");
      waitCapture();
      validQ.delete();
      applyStimulus(1'b1, 1'b0, 16'd0, 1'b1, 32'h10000000, 1'b1);
      fftCount = 0;
      idleCycles(3, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 16'd50, 1'b0, 32'd0, 1'b1);
      idleCycles(60, 1'b1, 1'b1);
      checkOutput("t4ValidCount", 32'(validQ.size()), 32'd13);
      checkOutput("t4First", qAt(0), 32'h0147AE14);
      checkOutput("t4Twelfth", qAt(11), 32'h0F5C28F0);
      checkOutput("t4Final", qAt(12), 32'h10000000);
      checkOutput("t4Hold", 32'(state), 32'(M_HOLD));
      checkOutput("t4NoCapture", 32'(fftCount), 32'd0);
      idleCycles(2, 1'b1, 1'b0);
      checkOutput("t4Recapture", 32'(state), 32'(M_CAPTURE));

      $display("[TB] uart and peak in the same cycle");
      applyStimulus(1'b1, 1'b1, 16'd20, 1'b1, 32'h00400000, 1'b0);
      idleCycles(70, 1'b0, 1'b0);
      checkOutput("t5Word", dds_word, 32'h00400000);
      checkOutput("t5Idle", 32'(state), 32'(M_IDLE));

      $display("[TB] reset during glide");
      waitCapture();
      applyStimulus(1'b1, 1'b1, 16'd100, 1'b0, 32'd0, 1'b0);
      idleCycles(8, 1'b1, 1'b0);
      doReset();
      checkOutput("t6WordCleared", dds_word, 32'd0);
      waitCapture();

      $display("[TB] random traffic");
      curMode = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 999) == 0) begin
            doReset();
            curMode = 1'b0;
            continue;
         end
         if ($urandom_range(0, 49) == 0) curMode = ~curMode;
         en = ($urandom_range(0, 9) != 0);
         pv = ($urandom_range(0, 19) == 0);
         pa = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
         uv = ($urandom_range(0, 149) == 0);
         uw = $urandom;
         applyStimulus(en, pv, pa, uv, uw, curMode);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
